load_vector: RTL and testbench

- DRAM-to-vector-buffer load unit; the opposite direction of the tile store path.
- Reads `length` bytes from DRAM starting at `dram_addr`, one element per cycle, through a fixed-latency read port.
- Packs the bytes into TILE_ELEMS-wide tiles and writes each tile into the shared vector buffer file under `buf_id`, using an enable/done handshake.
- Sits beside the store unit under the instruction executor.

---
 rtl/accel_pkg.sv | 9 +
 rtl/mem_read_tag_pipe.sv | 39 +++
 rtl/load_vector.sv | 162 ++++++++++++++++
 tb/tb_load_vector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared widths and the tile type used by the load/store units.
package accel_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TILE_WIDTH = 256;
    localparam int DEF_TILE_ELEMS = DEF_TILE_WIDTH / DEF_DATA_WIDTH;
    localparam int BUF_ID_W = 5;
    localparam int LEN_W = 10;
    typedef logic [DEF_DATA_WIDTH-1:0] tile_t [0:DEF_TILE_ELEMS-1];
endpackage

// File: rtl/mem_read_tag_pipe.sv
// mem_read_tag_pipe: DEPTH-stage shift register of {valid, idx} tags that
// follows DRAM reads so returning data lands in the right tile slot.
//   issue/issue_idx : read launched this cycle and its tile index
//   cap_valid/cap_idx : read data on mem_rdata belongs in tile[cap_idx]
//   empty : no read is in flight
module mem_read_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [IDX_W-1:0] issue_idx,
    output logic             cap_valid,
    output logic [IDX_W-1:0] cap_idx,
    output logic             empty
);
    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] tag [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) vld[i] <= vld[i-1];
            vld[0] <= issue;
        end
    end

    // Index tags need no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--) tag[i] <= tag[i-1];
        tag[0] <= issue_idx;
    end

    assign cap_valid = vld[DEPTH-1];
    assign cap_idx   = tag[DEPTH-1];
    assign empty     = ~|vld;
endmodule

// File: rtl/load_vector.sv
// load_vector: reads `length` bytes from DRAM at `dram_addr`, packs them into
// TILE_ELEMS-wide tiles and writes each tile to vector buffer `buf_id`.
//   start/dram_addr/length/buf_id : command, accepted only when idle
//   mem_re/mem_addr/mem_rdata     : fixed-latency (MEM_LATENCY) DRAM read port
//   buf_write_*                   : tile write request held until buf_write_done
//   busy/done                     : command in progress / one-cycle completion
module load_vector
    import accel_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TILE_WIDTH  = DEF_TILE_WIDTH,
    parameter int TILE_ELEMS  = TILE_WIDTH / DATA_WIDTH,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic [BUF_ID_W-1:0]   buf_id,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  buf_write_en,
    output logic [BUF_ID_W-1:0]   buf_write_id,
    output logic [DATA_WIDTH-1:0] buf_write_data [0:TILE_ELEMS-1],
    input  logic                  buf_write_done,
    output logic                  busy,
    output logic                  done
);
    localparam int IDX_W = $clog2(TILE_ELEMS);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_ADVANCE, S_FINISH} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] base, base_d, mem_addr_d;
    logic [LEN_W-1:0]      rem, rem_d, n;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [BUF_ID_W-1:0]   id_d;
    logic                  mem_re_d, en_d, done_d, busy_d, clr;
    logic                  cap_valid, empty;
    logic [IDX_W-1:0]      cap_idx;

    mem_read_tag_pipe #(.DEPTH(MEM_LATENCY), .IDX_W(IDX_W)) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (mem_re),
        .issue_idx (idx),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx),
        .empty     (empty)
    );

    always_comb begin
        n          = (rem >= LEN_W'(TILE_ELEMS)) ? LEN_W'(TILE_ELEMS) : rem;
        state_d    = state;
        base_d     = base;
        rem_d      = rem;
        idx_d      = idx;
        mem_re_d   = 1'b0;
        mem_addr_d = mem_addr;
        en_d       = buf_write_en;
        done_d     = 1'b0;
        busy_d     = busy;
        id_d       = buf_write_id;
        clr        = 1'b0;
        case (state)
            S_IDLE: begin
                // busy is still high during the done cycle; it drops here
                // and a start arriving in that cycle is treated as busy.
                if (busy) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    base_d  = dram_addr;
                    rem_d   = length;
                    id_d    = buf_id;
                    busy_d  = 1'b1;
                    state_d = (length == '0) ? S_FINISH : S_FETCH;
                    if (length != '0) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = dram_addr;
                        idx_d      = '0;
                        clr        = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (LEN_W'(idx) == n - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    mem_re_d   = 1'b1;
                    idx_d      = idx + IDX_W'(1);
                    mem_addr_d = mem_addr + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                state_d = empty ? S_WRITE : S_DRAIN;
                en_d    = empty;
            end
            S_WRITE: begin
                if (buf_write_done) begin
                    en_d    = 1'b0;
                    rem_d   = rem - n;
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                state_d = (rem != '0) ? S_FETCH : S_FINISH;
                if (rem != '0) begin
                    base_d     = base + ADDR_WIDTH'(TILE_ELEMS);
                    mem_re_d   = 1'b1;
                    mem_addr_d = base + ADDR_WIDTH'(TILE_ELEMS);
                    idx_d      = '0;
                    clr        = 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            base         <= '0;
            rem          <= '0;
            idx          <= '0;
            mem_re       <= 1'b0;
            mem_addr     <= '0;
            buf_write_en <= 1'b0;
            buf_write_id <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            base         <= base_d;
            rem          <= rem_d;
            idx          <= idx_d;
            mem_re       <= mem_re_d;
            mem_addr     <= mem_addr_d;
            buf_write_en <= en_d;
            buf_write_id <= id_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Clearing at tile start zero-pads a partial last tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TILE_ELEMS; i++) buf_write_data[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < TILE_ELEMS; i++) buf_write_data[i] <= '0;
        end else if (cap_valid) begin
            buf_write_data[cap_idx] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_load_vector.sv
// tb_load_vector: checks load_vector at MEM_LATENCY 1 and 3 side by side
// against a tile model computed from address arithmetic.
module tb_load_vector;
    import accel_pkg::*;

    typedef struct {
        logic [23:0] addr;
        int          len;
        logic [4:0]  id;
        int          dly;
        logic [7:0]  salt;
        int          reads;
        int          tiles;
        int          lat_lo;
        int          lat_hi;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [23:0] dram_addr = '0;
    logic [9:0]  length = '0;
    logic [4:0]  buf_id = '0;
    logic        re [2], en [2], wdone [2], busy [2], done_o [2];
    logic [23:0] maddr [2];
    logic [7:0]  rdata [2];
    logic [4:0]  wid [2];
    logic [7:0]  wd0 [0:31], wd1 [0:31];
    logic [7:0]  rp [2][3];
    logic [7:0]  salt = '0;
    int          dly = 0, cyc = 0, start_cyc = 0, nchk = 0, nerr = 0;
    int          wcnt [2];
    int          nreads [2], addr_err [2], en_cyc [2], ntiles [2], stab_err [2];
    int          id_err [2], re_in_en [2], ndone [2], lat [2];
    logic        en_prev [2];
    logic [255:0] snap [2];
    logic [255:0] tq0 [$], tq1 [$];
    logic [23:0] exp_base = '0;
    logic [4:0]  exp_id = '0;
    vec_t        vecs [6];

    load_vector #(.MEM_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .dram_addr(dram_addr), .length(length),
        .buf_id(buf_id), .mem_re(re[0]), .mem_addr(maddr[0]), .mem_rdata(rdata[0]),
        .buf_write_en(en[0]), .buf_write_id(wid[0]), .buf_write_data(wd0),
        .buf_write_done(wdone[0]), .busy(busy[0]), .done(done_o[0])
    );

    load_vector #(.MEM_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .dram_addr(dram_addr), .length(length),
        .buf_id(buf_id), .mem_re(re[1]), .mem_addr(maddr[1]), .mem_rdata(rdata[1]),
        .buf_write_en(en[1]), .buf_write_id(wid[1]), .buf_write_data(wd1),
        .buf_write_done(wdone[1]), .busy(busy[1]), .done(done_o[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM model: byte at address a is a[7:0]^salt, returned after 1 or 3 cycles;
    // slots with no read in flight carry 0xEE so a misaligned capture shows up.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rp[k][0] <= re[k] ? (maddr[k][7:0] ^ salt) : 8'hEE;
            rp[k][1] <= rp[k][0];
            rp[k][2] <= rp[k][1];
            wcnt[k]  <= en[k] ? wcnt[k] + 1 : 0;
        end
    end
    assign rdata[0] = rp[0][0];
    assign rdata[1] = rp[1][2];
    assign wdone[0] = en[0] && (wcnt[0] == dly);
    assign wdone[1] = en[1] && (wcnt[1] == dly);

    function automatic logic [255:0] pk(int k);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = (k == 0) ? wd0[i] : wd1[i];
        return r;
    endfunction

    function automatic logic [255:0] model(logic [23:0] a, int len, logic [7:0] s, int t);
        tile_t        et;
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            et[i] = (t * 32 + i < len) ? (8'(a + 24'(t * 32 + i)) ^ s) : 8'h00;
            r[i*8 +: 8] = et[i];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (re[k]) begin
                    if (maddr[k] != exp_base + 24'(nreads[k])) addr_err[k]++;
                    nreads[k]++;
                    if (en[k]) re_in_en[k]++;
                end
                if (en[k]) begin
                    en_cyc[k]++;
                    if (wid[k] != exp_id) id_err[k]++;
                    if (!en_prev[k]) begin
                        snap[k] = pk(k);
                        ntiles[k]++;
                        if (k == 0) tq0.push_back(pk(k));
                        else tq1.push_back(pk(k));
                    end else if (pk(k) != snap[k]) begin
                        stab_err[k]++;
                    end
                end
                if (done_o[k]) begin
                    ndone[k]++;
                    lat[k] = cyc - start_cyc;
                end
                en_prev[k] = en[k];
            end
        end
    end

    task automatic chk(string nm, int k, longint act, longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s (inst %0d): got %0d, expected %0d", nm, k, act, exp);
        end
    endtask

    task automatic chk_rng(string nm, int k, int act, int lo, int hi);
        nchk++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s (inst %0d): got %0d, expected %0d..%0d", nm, k, act, lo, hi);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            nreads[k] = 0; addr_err[k] = 0; en_cyc[k] = 0; ntiles[k] = 0; stab_err[k] = 0;
            id_err[k] = 0; re_in_en[k] = 0; ndone[k] = 0; lat[k] = -1; en_prev[k] = 1'b0;
        end
        tq0.delete();
        tq1.delete();
    endtask

    task automatic run_cmd(vec_t v);
        int t;
        logic [255:0] got;
        @(negedge clk);
        #1;
        clear_mon();
        salt = v.salt; dly = v.dly; exp_base = v.addr; exp_id = v.id;
        dram_addr = v.addr; length = 10'(v.len); buf_id = v.id;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        dram_addr = $urandom; length = 10'($urandom); buf_id = 5'($urandom);
        if (v.len >= 4) begin
            repeat (2) @(negedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        t = 0;
        while ((ndone[0] == 0 || ndone[1] == 0 || busy[0] || busy[1]) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("completion_timeout", 0, t < 4000, 1);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("read_count", k, nreads[k], v.reads);
            chk("read_addr_errors", k, addr_err[k], 0);
            chk("tile_writes", k, ntiles[k], v.tiles);
            for (int tt = 0; tt < v.tiles && tt < ntiles[k]; tt++) begin
                got = (k == 0) ? tq0[tt] : tq1[tt];
                nchk++;
                if (got != model(v.addr, v.len, v.salt, tt)) begin
                    nerr++;
                    $display("FAIL tile_data (inst %0d tile %0d): got %h, expected %h",
                             k, tt, got, model(v.addr, v.len, v.salt, tt));
                end
            end
            chk("write_en_cycles", k, en_cyc[k], v.tiles * (v.dly + 1));
            chk("write_data_unstable", k, stab_err[k], 0);
            chk("reads_during_write", k, re_in_en[k], 0);
            chk("write_id_errors", k, id_err[k], 0);
            chk("done_pulses", k, ndone[k], 1);
            chk_rng("done_latency", k, lat[k], v.lat_lo, v.lat_hi);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{24'h000100, 32,   5'd3,  0, 8'h00, 32,   1,  0, 40};
        vecs[1] = '{24'h000200, 40,   5'd7,  0, 8'h00, 40,   2,  0, 100000};
        vecs[2] = '{24'h000300, 0,    5'd1,  0, 8'h00, 0,    0,  2, 2};
        vecs[3] = '{24'h000400, 32,   5'd9,  5, 8'h5A, 32,   1,  0, 100000};
        vecs[4] = '{24'h000500, 33,   5'd2,  0, 8'h33, 33,   2,  0, 100000};
        vecs[5] = '{24'hFFFFF0, 1023, 5'd31, 1, 8'hC3, 1023, 32, 0, 100000};
        clear_mon();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_mem_re", k, re[k], 0);
            chk("reset_buf_write_en", k, en[k], 0);
            chk("reset_done", k, done_o[k], 0);
            chk("reset_busy", k, busy[k], 0);
            chk("reset_mem_addr", k, maddr[k], 0);
            chk("reset_tile_zero", k, pk(k) == '0, 1);
        end
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Abort a command mid-fetch with a one-cycle reset, then load 5 bytes.
        @(negedge clk);
        #1;
        clear_mon();
        dram_addr = 24'h777700; length = 10'd100; buf_id = 5'd4; salt = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_busy_cleared", k, busy[k], 0);
            chk("abort_mem_re_cleared", k, re[k], 0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("abort_no_done", k, ndone[k], 0);
        run_cmd('{24'h001000, 5, 5'd12, 0, 8'h6B, 5, 1, 0, 100000});

        for (int r = 0; r < 6; r++) begin
            v.addr  = 24'($urandom);
            v.len   = $urandom_range(0, 100);
            v.id    = 5'($urandom);
            v.dly   = $urandom_range(0, 3);
            v.salt  = 8'($urandom);
            v.reads = v.len;
            v.tiles = (v.len + 31) / 32;
            v.lat_lo = (v.len == 0) ? 2 : 0;
            v.lat_hi = (v.len == 0) ? 2 : 100000;
            run_cmd(v);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
